serial_sub: RTL and testbench
=============================

SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-002 The module SHALL have port s_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port s_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The module SHALL have port s_start, input, 1 bit: request to start a subtraction.
REQ-005 The module SHALL have ports s_A and s_B, input, WIDTH bits each: minuend and subtrahend, unsigned.
REQ-006 The module SHALL have port s_Bin, input, 1 bit: borrow-in.
REQ-007 The module SHALL have port s_Diff, output, WIDTH bits: registered difference.
REQ-008 The module SHALL have port s_Bout, output, 1 bit: registered borrow-out.
REQ-009 The module SHALL have port s_busy, output, 1 bit: operation in progress.
REQ-010 The module SHALL have port s_done, output, 1 bit: one-cycle result-valid pulse.

Function
REQ-011 The module SHALL compute s_Diff = (s_A - s_B - s_Bin) mod 2^WIDTH, with s_Bout = 1 exactly when s_A < s_B + s_Bin.
REQ-012 The module SHALL have FSM states IDLE, SHIFT and DONE.
REQ-013 In IDLE, a high s_start sampled at clock edge E SHALL latch s_A, s_B and s_Bin, clear the bit counter, set s_busy and move the FSM to SHIFT.
REQ-014 In SHIFT, edges E+1 through E+WIDTH SHALL each process one bit, LSB first, through a one-bit full subtractor, with the borrow carried in a flop between edges.
REQ-015 On edge E+WIDTH, the module SHALL update s_Diff and s_Bout, clear s_busy, set s_done and move the FSM to DONE.
REQ-016 On edge E+WIDTH+1, the module SHALL clear s_done and move the FSM to IDLE; s_done SHALL therefore be high for exactly one cycle.
REQ-017 s_Diff and s_Bout SHALL change only at the edge that completes an operation or at reset, and SHALL hold otherwise.
REQ-018 s_start SHALL be ignored in SHIFT and DONE; inputs changing during SHIFT SHALL not affect the result.
REQ-019 With s_start held high continuously, a new operation SHALL begin at every IDLE edge, giving back-to-back operations every WIDTH+2 cycles.
REQ-020 The bit counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL not wrap within an operation.

Reset
REQ-021 While s_rst is high, the module SHALL immediately, without waiting for a clock edge, force: FSM state IDLE, s_Diff 0, s_Bout 0, s_busy 0, s_done 0, counter 0, internal borrow 0.
REQ-022 Reset asserted mid-operation SHALL abort the operation with no s_done pulse.
REQ-023 s_start SHALL not be accepted while s_rst is high; the first acceptance SHALL be at the first edge after s_rst deasserts.

Configuration
REQ-024 With macro SERIAL_SUB_OVF_EN defined, the module SHALL add output port s_Ovf, 1 bit.
REQ-025 s_Ovf SHALL be the two's-complement signed-overflow flag of s_A - s_B - s_Bin, registered alongside s_Diff and reset to 0.
REQ-026 Without SERIAL_SUB_OVF_EN defined, the port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-027 Package serial_sub_pkg SHALL hold the WIDTH default constant, the FSM state enumeration (IDLE, SHIFT, DONE) and the counter-width constant.
REQ-028 The one-bit full subtractor SHALL be a separate sub-module, fs1, with inputs a, b, bin and outputs d, bout; serial_sub SHALL instantiate it once.

Verification
REQ-029 Basic subtraction: s_A=8'h03, s_B=8'h01, s_Bin=0, start pulse -> s_done pulses 9 edges after start; s_Diff=8'h02, s_Bout=0.
REQ-030 Borrow out: s_A=8'h01, s_B=8'h03, s_Bin=0 -> s_Diff=8'hFE, s_Bout=1; with SERIAL_SUB_OVF_EN, s_Ovf=0.
REQ-031 Borrow in, wrap-around: s_A=8'h00, s_B=8'h00, s_Bin=1 -> s_Diff=8'hFF, s_Bout=1.
REQ-032 Signed overflow: s_A=8'h80, s_B=8'h01, s_Bin=0 -> s_Diff=8'h7F, s_Bout=0; with SERIAL_SUB_OVF_EN, s_Ovf=1.
REQ-033 Start while busy: start with 8'h10 - 8'h05; 3 cycles later pulse start with 8'hFF - 8'h00 -> second start ignored; s_Diff=8'h0B, single s_done pulse.
REQ-034 Reset mid-operation: assert s_rst 4 cycles after start -> all outputs 0 at once, no s_done; a new start after release gives a correct result.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared constants and FSM state type for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int SS_WIDTH = 8;

    function automatic int ss_cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int SS_CNT_W = ss_cnt_w(SS_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ss_state_t;

endpackage

// File: rtl/serial_sub_fs1.sv
// One-bit full subtractor: d = a - b - bin, bout = borrow out.
module fs1 (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & (b | bin)) | (b & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor, LSB first, WIDTH+2 cycles per operation.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output s_Ovf.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SS_WIDTH
) (
    input  logic             s_clk,
    input  logic             s_rst,
    input  logic             s_start,
    input  logic [WIDTH-1:0] s_A,
    input  logic [WIDTH-1:0] s_B,
    input  logic             s_Bin,
    output logic [WIDTH-1:0] s_Diff,
    output logic             s_Bout,
    output logic             s_busy,
    output logic             s_done
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             s_Ovf
`endif
);

    localparam int CW = ss_cnt_w(WIDTH);

    ss_state_t        r_state;
    ss_state_t        w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-2:0] r_acc;
    logic             r_brw;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             w_d;
    logic             w_bout;
    logic             w_last;
    logic             w_accept;
    logic [WIDTH-1:0] w_acc;

    fs1 u_fs1 (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_brw),
        .d    (w_d),
        .bout (w_bout)
    );

    assign w_last   = (r_cnt == CW'(WIDTH - 1));
    assign w_accept = (r_state == IDLE) && s_start;
    // Newest bit enters at the top, so the final word is already aligned.
    assign w_acc    = {w_d, r_acc};

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (s_start) w_state_nxt = SHIFT;
            SHIFT:   if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            r_cnt  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_brw  <= 1'b0;
            r_diff <= '0;
            r_bout <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_a   <= s_A;
            r_b   <= s_B;
            r_brw <= s_Bin;
        end else if (r_state == SHIFT) begin
            r_cnt <= r_cnt + CW'(1);
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_brw <= w_bout;
            r_acc <= w_acc[WIDTH-1:1];
            if (w_last) begin
                r_diff <= w_acc;
                r_bout <= w_bout;
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic r_ovf;

    // On the last bit r_a[0]/r_b[0] hold the operand sign bits.
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == SHIFT && w_last) begin
            r_ovf <= (r_a[0] ^ r_b[0]) & (r_a[0] ^ w_d);
        end
    end

    assign s_Ovf = r_ovf;
`endif

    assign s_Diff = r_diff;
    assign s_Bout = r_bout;
    assign s_busy = (r_state == SHIFT);
    assign s_done = (r_state == DONE);

endmodule

// File: tb/tb_serial_sub.sv
// Directed self-checking bench for serial_sub (WIDTH = 8).
module tb_serial_sub;

    logic       s_clk;
    logic       s_rst;
    logic       s_start;
    logic [7:0] s_A;
    logic [7:0] s_B;
    logic       s_Bin;
    logic [7:0] s_Diff;
    logic       s_Bout;
    logic       s_busy;
    logic       s_done;
`ifdef SERIAL_SUB_OVF_EN
    logic       s_Ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    serial_sub #(.WIDTH(8)) dut (
        .s_clk   (s_clk),
        .s_rst   (s_rst),
        .s_start (s_start),
        .s_A     (s_A),
        .s_B     (s_B),
        .s_Bin   (s_Bin),
        .s_Diff  (s_Diff),
        .s_Bout  (s_Bout),
        .s_busy  (s_busy),
        .s_done  (s_done)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .s_Ovf   (s_Ovf)
`endif
    );

    initial s_clk = 1'b0;
    always #5 s_clk = ~s_clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Start one op, scramble inputs while busy, check latency and result.
    task automatic run_op(input string tag, input logic [7:0] a,
                          input logic [7:0] b, input logic bin,
                          input logic [7:0] ed, input logic eb,
                          input logic eo);
        int edges;
        @(negedge s_clk);
        s_A = a; s_B = b; s_Bin = bin; s_start = 1'b1;
        @(posedge s_clk); #1;
        edges = 1;
        chk({tag, "_busy"}, 32'(s_busy), 32'd1);
        @(negedge s_clk);
        s_start = 1'b0; s_A = ~a; s_B = ~b; s_Bin = ~bin;
        while (!s_done && edges < 40) begin
            @(posedge s_clk); #1;
            edges++;
        end
        chk({tag, "_lat"}, 32'(edges), 32'd9);
        chk({tag, "_diff"}, 32'(s_Diff), 32'(ed));
        chk({tag, "_bout"}, 32'(s_Bout), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
        chk({tag, "_ovf"}, 32'(s_Ovf), 32'(eo));
`else
        if (eo === 1'bx) $display("unused");
`endif
        @(posedge s_clk); #1;
        chk({tag, "_done_lo"}, 32'(s_done), 32'd0);
        chk({tag, "_hold"}, 32'(s_Diff), 32'(ed));
    endtask

    initial begin
        int dones;
        int edges;
        int t1;
        s_rst = 1'b1; s_start = 1'b0;
        s_A = '0; s_B = '0; s_Bin = 1'b0;
        #1;
        chk("rst_diff", 32'(s_Diff), 32'd0);
        chk("rst_bout", 32'(s_Bout), 32'd0);
        chk("rst_busy", 32'(s_busy), 32'd0);
        chk("rst_done", 32'(s_done), 32'd0);
        repeat (2) @(posedge s_clk);
        @(negedge s_clk);
        s_rst = 1'b0;

        run_op("basic",  8'h03, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
        run_op("borrow", 8'h01, 8'h03, 1'b0, 8'hFE, 1'b1, 1'b0);
        run_op("binwrap",8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_op("sovf",   8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        run_op("ffff",   8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_op("55aa",   8'h55, 8'hAA, 1'b0, 8'hAB, 1'b1, 1'b1);

        // Start while busy must be ignored.
        @(negedge s_clk);
        s_A = 8'h10; s_B = 8'h05; s_Bin = 1'b0; s_start = 1'b1;
        @(posedge s_clk);
        @(negedge s_clk);
        s_start = 1'b0;
        repeat (2) @(posedge s_clk);
        @(negedge s_clk);
        s_A = 8'hFF; s_B = 8'h00; s_start = 1'b1;
        @(posedge s_clk);
        @(negedge s_clk);
        s_start = 1'b0;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge s_clk); #1;
            if (s_done) dones++;
        end
        chk("busy_dones", 32'(dones), 32'd1);
        chk("busy_diff", 32'(s_Diff), 32'h0B);

        // Reset mid-operation, start held high through reset.
        @(negedge s_clk);
        s_A = 8'h44; s_B = 8'h11; s_start = 1'b1;
        @(posedge s_clk);
        @(negedge s_clk);
        s_start = 1'b0;
        repeat (4) @(posedge s_clk);
        #2;
        s_rst = 1'b1;
        #1;
        chk("mrst_diff", 32'(s_Diff), 32'd0);
        chk("mrst_busy", 32'(s_busy), 32'd0);
        chk("mrst_done", 32'(s_done), 32'd0);
        s_start = 1'b1; s_A = 8'h20; s_B = 8'h07; s_Bin = 1'b0;
        dones = 0;
        repeat (2) begin
            @(posedge s_clk); #1;
            if (s_busy || s_done) dones++;
        end
        chk("mrst_idle", 32'(dones), 32'd0);
        @(negedge s_clk);
        s_rst = 1'b0;
        @(posedge s_clk); #1;
        chk("mrst_accept", 32'(s_busy), 32'd1);
        @(negedge s_clk);
        s_start = 1'b0;
        edges = 1;
        while (!s_done && edges < 40) begin
            @(posedge s_clk); #1;
            edges++;
        end
        chk("mrst_lat", 32'(edges), 32'd9);
        chk("mrst_res", 32'(s_Diff), 32'h19);

        // Back-to-back with start held high: period WIDTH+2.
        @(negedge s_clk);
        s_A = 8'h05; s_B = 8'h02; s_Bin = 1'b0; s_start = 1'b1;
        edges = 0;
        t1 = -1;
        dones = 0;
        while (dones < 2 && edges < 60) begin
            @(posedge s_clk); #1;
            edges++;
            if (s_done) begin
                if (dones == 0) t1 = edges;
                else chk("b2b_period", 32'(edges - t1), 32'd10);
                dones++;
            end
        end
        chk("b2b_count", 32'(dones), 32'd2);
        chk("b2b_diff", 32'(s_Diff), 32'h03);
        @(negedge s_clk);
        s_start = 1'b0;
        repeat (12) @(posedge s_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
